// File: rtl/prime_scan_gen.sv
// prime_scan_gen: scans every integer in [NumMin, NumMax]. Each candidate is
// tested for primality by trial division with a restoring divider. Primes are
// streamed on a valid/ready port. The block also reports running checked,
// prime and cycle counts.
//
// Handshake: PrimeValid/PrimeOut are registered. Once PrimeValid rises,
// PrimeOut holds stable and PrimeValid stays high until the first rising edge
// at which PrimeReady is 1. That edge is the transfer. PrimeValid then drops
// at the same edge. A reset drops a pending prime without transferring it.
module prime_scan_gen #(
  parameter int N_W   = 10,
  parameter int CNT_W = 8,
  parameter int CYC_W = 32
) (
  input  logic             SysClk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [N_W-1:0]   NumMin,
  input  logic [N_W-1:0]   NumMax,
  input  logic             PrimeReady,
  output logic             Busy,
  output logic             Done,
  output logic             PrimeValid,
  output logic [N_W-1:0]   PrimeOut,
  output logic [N_W-1:0]   NumberChecked,
  output logic [CNT_W-1:0] NumberofPrimesFound,
  output logic [CYC_W-1:0] CycleCount,
  output logic             Overflow,
  output logic [2:0]       state_dbg
);

  localparam int DCW = $clog2(N_W + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_TEST = 3'd2,
    S_DIV  = 3'd3,
    S_EMIT = 3'd4,
    S_NEXT = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t           state_q;
  logic [N_W-1:0]   min_q;
  logic [N_W-1:0]   max_q;
  logic [N_W-1:0]   n_q;
  logic [N_W-1:0]   d_q;
  logic [N_W-1:0]   rem_q;
  logic [N_W-1:0]   dvd_q;
  logic [DCW-1:0]   div_cnt_q;

  logic [N_W:0]     rem_shift;
  logic [N_W:0]     rem_next;
  logic [2*N_W-1:0] d_sq;

  assign state_dbg = state_q;

  // One restoring-division step, plus the full-width d*d used for the sqrt bound.
  always_comb begin
    rem_shift = {rem_q, dvd_q[N_W-1]};
    rem_next  = rem_shift;
    if (rem_shift >= {1'b0, d_q}) begin
      rem_next = rem_shift - {1'b0, d_q};
    end
    d_sq = (2*N_W)'(d_q) * (2*N_W)'(d_q);
  end

  // Scan controller: the state register, the datapath and all registered outputs.
  always_ff @(posedge SysClk) begin
    if (!Reset) begin
      state_q             <= S_IDLE;
      min_q               <= '0;
      max_q               <= '0;
      n_q                 <= '0;
      d_q                 <= '0;
      rem_q               <= '0;
      dvd_q               <= '0;
      div_cnt_q           <= '0;
      Busy                <= 1'b0;
      Done                <= 1'b0;
      PrimeValid          <= 1'b0;
      PrimeOut            <= '0;
      NumberChecked       <= '0;
      NumberofPrimesFound <= '0;
      CycleCount          <= '0;
      Overflow            <= 1'b0;
    end else begin
      if (Busy && (CycleCount != {CYC_W{1'b1}})) begin
        CycleCount <= CycleCount + CYC_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            min_q               <= NumMin;
            max_q               <= NumMax;
            n_q                 <= NumMin;
            NumberofPrimesFound <= '0;
            NumberChecked       <= '0;
            Overflow            <= 1'b0;
            CycleCount          <= '0;
            Busy                <= 1'b1;
            state_q             <= S_LOAD;
          end
        end
        S_LOAD: begin
          d_q <= N_W'(2);
          if (min_q > max_q) begin
            Busy    <= 1'b0;
            Done    <= 1'b1;
            state_q <= S_DONE;
          end else if (n_q < N_W'(2)) begin
            state_q <= S_NEXT;
          end else if ((n_q == N_W'(2)) || (n_q == N_W'(3))) begin
            PrimeValid <= 1'b1;
            PrimeOut   <= n_q;
            state_q    <= S_EMIT;
          end else begin
            state_q <= S_TEST;
          end
        end
        S_TEST: begin
          if (d_sq > (2*N_W)'(n_q)) begin
            PrimeValid <= 1'b1;
            PrimeOut   <= n_q;
            state_q    <= S_EMIT;
          end else begin
            rem_q     <= '0;
            dvd_q     <= n_q;
            div_cnt_q <= '0;
            state_q   <= S_DIV;
          end
        end
        S_DIV: begin
          rem_q     <= rem_next[N_W-1:0];
          dvd_q     <= {dvd_q[N_W-2:0], 1'b0};
          div_cnt_q <= div_cnt_q + DCW'(1);
          if (div_cnt_q == DCW'(N_W - 1)) begin
            if (rem_next == '0) begin
              state_q <= S_NEXT;
            end else begin
              d_q     <= d_q + N_W'(1);
              state_q <= S_TEST;
            end
          end
        end
        S_EMIT: begin
          if (PrimeReady) begin
            PrimeValid <= 1'b0;
            if (NumberofPrimesFound == {CNT_W{1'b1}}) begin
              Overflow <= 1'b1;
            end else begin
              NumberofPrimesFound <= NumberofPrimesFound + CNT_W'(1);
            end
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          NumberChecked <= n_q;
          // Compare for equality rather than testing n+1 > max, so an
          // all-ones upper bound never wraps.
          if (n_q == max_q) begin
            Busy    <= 1'b0;
            Done    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            n_q     <= n_q + N_W'(1);
            state_q <= S_LOAD;
          end
        end
        S_DONE: begin
          Done    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          Done    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prime_scan_gen.sv
// Bench for prime_scan_gen. It uses a table of scan vectors, an expected-prime
// queue and hand-written sequences for the reset and saturation corner cases.
module tb_prime_scan_gen;

  localparam int N_W     = 10;
  localparam int BUDGET  = 90000;
  localparam int ST_IDLE = 0;
  localparam int ST_DIV  = 3;

  // clock / reset block
  logic SysClk = 1'b0;
  always #5 SysClk = ~SysClk;
  logic Reset = 1'b0;

  logic           Start = 1'b0;
  logic [N_W-1:0] NumMin = '0;
  logic [N_W-1:0] NumMax = '0;
  logic           PrimeReady = 1'b1;
  logic           Busy, Done, PrimeValid, Overflow;
  logic [N_W-1:0] PrimeOut, NumberChecked;
  logic [7:0]     NumberofPrimesFound;
  logic [31:0]    CycleCount;
  logic [2:0]     state_dbg;

  prime_scan_gen #(.N_W(N_W), .CNT_W(8), .CYC_W(32)) dut (
    .SysClk(SysClk), .Reset(Reset), .Start(Start), .NumMin(NumMin), .NumMax(NumMax),
    .PrimeReady(PrimeReady), .Busy(Busy), .Done(Done), .PrimeValid(PrimeValid),
    .PrimeOut(PrimeOut), .NumberChecked(NumberChecked),
    .NumberofPrimesFound(NumberofPrimesFound), .CycleCount(CycleCount),
    .Overflow(Overflow), .state_dbg(state_dbg)
  );

  // second instance with a narrow prime counter, for the saturation case
  logic           s2_start = 1'b0;
  logic [N_W-1:0] s2_min = '0;
  logic [N_W-1:0] s2_max = '0;
  logic           s2_ready = 1'b1;
  logic           o2_busy, o2_done, o2_valid, o2_ovf;
  logic [N_W-1:0] o2_out, o2_chk;
  logic [3:0]     o2_cnt;
  logic [31:0]    o2_cyc;
  logic [2:0]     o2_state;

  prime_scan_gen #(.N_W(N_W), .CNT_W(4), .CYC_W(32)) dut2 (
    .SysClk(SysClk), .Reset(Reset), .Start(s2_start), .NumMin(s2_min), .NumMax(s2_max),
    .PrimeReady(s2_ready), .Busy(o2_busy), .Done(o2_done), .PrimeValid(o2_valid),
    .PrimeOut(o2_out), .NumberChecked(o2_chk), .NumberofPrimesFound(o2_cnt),
    .CycleCount(o2_cyc), .Overflow(o2_ovf), .state_dbg(o2_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_prime(input int k);
    if (k < 2) return 1'b0;
    for (int d = 2; d * d <= k; d++) begin
      if (k % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // scoreboard
  logic [N_W-1:0] exp_q[$];
  bit             sb_en = 1'b0;
  int             hs_cnt, done_cnt, busy_cyc, first_p, last_p;
  logic           prev_stall = 1'b0;
  logic [N_W-1:0] prev_out = '0;

  always @(negedge SysClk) begin
    if (sb_en) begin
      if (Busy) busy_cyc++;
      if (Done) done_cnt++;
      if (prev_stall) begin
        check("stall_valid_held", PrimeValid, 1);
        check("stall_out_held", PrimeOut, prev_out);
      end
      if (PrimeValid && PrimeReady) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_prime: got %0d, expected no further prime", PrimeOut);
        end else begin
          check("prime_stream", PrimeOut, exp_q.pop_front());
        end
        if (hs_cnt == 0) first_p = int'(PrimeOut);
        last_p = int'(PrimeOut);
        hs_cnt++;
      end
      prev_stall = PrimeValid && !PrimeReady;
      prev_out   = PrimeOut;
    end else begin
      prev_stall = 1'b0;
    end
  end

  typedef struct {
    int lo;
    int hi;
    int rnd;
    int poke;
    int exp_cnt;
    int exp_first;
    int exp_last;
    int exp_chk;
  } vec_t;

  vec_t vecs[9];

  // driver: one complete scan described by a table row
  task automatic run_scan(input vec_t v);
    int  cycles;
    bit  seen_done;
    exp_q.delete();
    for (int k = v.lo; k <= v.hi; k++) begin
      if (is_prime(k)) exp_q.push_back(N_W'(k));
    end
    hs_cnt = 0; done_cnt = 0; busy_cyc = 0; first_p = -1; last_p = -1;
    @(posedge SysClk); #1;
    NumMin = N_W'(v.lo);
    NumMax = N_W'(v.hi);
    PrimeReady = (v.rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    Start = 1'b1;
    sb_en = 1'b1;
    @(posedge SysClk); #1;
    Start = 1'b0;
    check("busy_after_start", Busy, 1);
    cycles = 0;
    seen_done = 1'b0;
    while (!seen_done && cycles < BUDGET) begin
      @(posedge SysClk); #1;
      cycles++;
      if (v.rnd != 0) PrimeReady = 1'($urandom_range(0, 1));
      Start = (v.poke != 0) && (cycles == 4);
      if (Start) begin
        NumMin = '0;
        NumMax = N_W'(1000);
      end
      if (Done) seen_done = 1'b1;
    end
    Start = 1'b0;
    if (!seen_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL scan_timeout: no Done within %0d cycles for [%0d,%0d]", BUDGET, v.lo, v.hi);
    end
    check("busy_low_in_done", Busy, 0);
    if (v.lo > v.hi) check("empty_range_done_latency_le3", (cycles <= 3), 1);
    @(posedge SysClk); #1;
    sb_en = 1'b0;
    PrimeReady = 1'b1;
    check("done_one_cycle", Done, 0);
    check("done_pulse_count", done_cnt, 1);
    check("handshake_count", hs_cnt, v.exp_cnt);
    check("primes_found", NumberofPrimesFound, v.exp_cnt);
    check("number_checked", NumberChecked, v.exp_chk);
    check("overflow_clear", Overflow, 0);
    check("cycle_count", CycleCount, busy_cyc);
    check("stream_leftover", exp_q.size(), 0);
    check("valid_low_after", PrimeValid, 0);
    if (v.exp_cnt > 0) begin
      check("first_prime", first_p, v.exp_first);
      check("last_prime", last_p, v.exp_last);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_valid"}, PrimeValid, 0);
    check({tag, "_out"}, PrimeOut, 0);
    check({tag, "_checked"}, NumberChecked, 0);
    check({tag, "_found"}, NumberofPrimesFound, 0);
    check({tag, "_cycles"}, CycleCount, 0);
    check({tag, "_overflow"}, Overflow, 0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // reset asserted while the divider is running, or while a prime is stalled
  task automatic reset_mid(input bit during_emit);
    int cycles;
    @(posedge SysClk); #1;
    NumMin = '0;
    NumMax = during_emit ? N_W'(100) : N_W'(1000);
    PrimeReady = during_emit ? 1'b0 : 1'b1;
    Start = 1'b1;
    @(posedge SysClk); #1;
    Start = 1'b0;
    cycles = 0;
    while (cycles < 500 && !(during_emit ? PrimeValid : (int'(state_dbg) == ST_DIV))) begin
      @(posedge SysClk); #1;
      cycles++;
    end
    check(during_emit ? "reach_emit" : "reach_div", (cycles < 500), 1);
    if (during_emit) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge SysClk); #1;
        check("emit_stall_valid", PrimeValid, 1);
        check("emit_stall_out", PrimeOut, 2);
      end
    end
    check("busy_before_reset", Busy, 1);
    Reset = 1'b0;
    @(posedge SysClk); #1;
    check_all_zero(during_emit ? "rst_emit" : "rst_div");
    Reset = 1'b1;
    PrimeReady = 1'b1;
    @(posedge SysClk); #1;
    check(during_emit ? "idle_after_rst_emit" : "idle_after_rst_div", state_dbg, ST_IDLE);
  endtask

  initial begin
    vecs[0] = '{2,    3,    0, 0, 2,   2,    3,    3};
    vecs[1] = '{0,    1,    0, 0, 0,   0,    0,    1};
    vecs[2] = '{90,   100,  0, 0, 1,   97,   97,   100};
    vecs[3] = '{90,   100,  0, 1, 1,   97,   97,   100};
    vecs[4] = '{1020, 1023, 0, 0, 1,   1021, 1021, 1023};
    vecs[5] = '{5,    3,    0, 0, 0,   0,    0,    0};
    vecs[6] = '{0,    100,  1, 0, 25,  2,    97,   100};
    vecs[7] = '{997,  997,  0, 0, 1,   997,  997,  997};
    vecs[8] = '{0,    1000, 1, 0, 168, 2,    997,  1000};

    Reset = 1'b0;
    repeat (3) @(posedge SysClk);
    #1;
    check_all_zero("reset");
    Reset = 1'b1;

    for (int i = 0; i < 8; i++) run_scan(vecs[i]);

    reset_mid(1'b0);
    reset_mid(1'b1);

    // narrow counter: 25 primes in [0,100] saturate a 4-bit count at 15
    begin
      int seen;
      int cycles;
      @(posedge SysClk); #1;
      s2_min = '0;
      s2_max = N_W'(100);
      s2_ready = 1'b1;
      s2_start = 1'b1;
      @(posedge SysClk); #1;
      s2_start = 1'b0;
      seen = 0;
      cycles = 0;
      while (!o2_done && cycles < BUDGET) begin
        if (o2_valid) seen++;
        @(posedge SysClk); #1;
        cycles++;
      end
      check("sat_done_seen", o2_done, 1);
      check("sat_streamed", seen, 25);
      check("sat_count", o2_cnt, 15);
      check("sat_overflow", o2_ovf, 1);
      check("sat_checked", o2_chk, 100);
    end

    run_scan(vecs[8]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
